// File: rtl/mmc3_pkg.sv
// rtl/mmc3_pkg.sv - shared types and constants for the MMC3-family mapper core
// SST address constants exist only when MMC3_SST_EN is defined.
package mmc3_pkg;

  typedef enum logic [1:0] {
    MODE_MMC3B = 2'd0,
    MODE_MMC3A = 2'd1,
    MODE_RAMBO = 2'd2,
    MODE_RSVD  = 2'd3
  } map_mode_t;

  // {a14, a13, a0} of a $8000-$FFFF write
  typedef enum logic [2:0] {
    REG_BANK_SEL   = 3'd0,
    REG_BANK_DATA  = 3'd1,
    REG_MIRROR     = 3'd2,
    REG_PRG_RAM    = 3'd3,
    REG_IRQ_LATCH  = 3'd4,
    REG_IRQ_RELOAD = 3'd5,
    REG_IRQ_DIS    = 3'd6,
    REG_IRQ_EN     = 3'd7
  } reg_sel_t;

  localparam logic [3:0] IDX_R8 = 4'd8;
  localparam logic [3:0] IDX_R9 = 4'd9;
  localparam logic [3:0] IDX_RF = 4'd15;

`ifdef MMC3_SST_EN
  localparam logic [7:0] SST_R8000 = 8'd16;
  localparam logic [7:0] SST_A000  = 8'd17;
  localparam logic [7:0] SST_A001  = 8'd18;
  localparam logic [7:0] SST_LATCH = 8'd19;
  localparam logic [7:0] SST_CNT   = 8'd20;
  localparam logic [7:0] SST_FLAGS = 8'd21;
`endif

  function automatic logic [7:0] bank_reset(input logic [3:0] idx);
    case (idx)
      4'd1:    bank_reset = 8'd2;
      4'd2:    bank_reset = 8'd4;
      4'd3:    bank_reset = 8'd5;
      4'd4:    bank_reset = 8'd6;
      4'd5:    bank_reset = 8'd7;
      4'd7:    bank_reset = 8'd1;
      4'd8:    bank_reset = 8'd1;
      4'd9:    bank_reset = 8'd3;
      default: bank_reset = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/mmc3_irq_ctr.sv
// rtl/mmc3_irq_ctr.sv - scanline/CPU-cycle IRQ counter with A12 filter and prescaler
// Snapshot ports exist only when MMC3_SST_EN is defined.
module mmc3_irq_ctr import mmc3_pkg::*; #(
  parameter int A12_FILT = 3,
  parameter int CYC_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_commit,
  input  logic [2:0] i_sel,
  input  logic [7:0] i_data,
  input  logic       i_a12,
  input  logic       i_m2_fall,
  input  logic [1:0] i_mode,
`ifdef MMC3_SST_EN
  input  logic       i_freeze,
  input  logic       i_sst_we,
  input  logic [7:0] i_sst_addr,
  input  logic [7:0] i_sst_di,
  output logic [7:0] o_latch,
  output logic [7:0] o_cnt,
  output logic [3:0] o_flags,
`endif
  output logic       o_irq_n
);

  localparam int FW = $clog2(A12_FILT + 1);
  localparam int PW = (CYC_DIV > 1) ? $clog2(CYC_DIV) : 1;

  logic [FW-1:0] r_filt;
  logic [PW-1:0] r_pre;
  logic [7:0]    r_latch, r_cnt;
  logic          r_a12_d, r_reload, r_en, r_pend, r_cyc;

  map_mode_t w_mode;
  logic      w_rambo, w_cyc, w_run, w_clk_ev, w_hit;
  logic [7:0] w_next;

  assign w_mode  = map_mode_t'(i_mode);
  assign w_rambo = (w_mode == MODE_RAMBO);
  assign w_cyc   = w_rambo & r_cyc;
`ifdef MMC3_SST_EN
  assign w_run   = ~i_freeze;
`else
  assign w_run   = 1'b1;
`endif

  assign w_clk_ev = w_cyc ? (i_m2_fall & (r_pre == PW'(CYC_DIV - 1)))
                          : (i_a12 & ~r_a12_d & (r_filt >= FW'(A12_FILT)));
  assign w_next   = (r_cnt == 8'd0 || r_reload) ? r_latch : r_cnt - 8'd1;
  // MMC3A only fires on a real 1->0 step or an explicit reload to zero
  assign w_hit    = (w_mode == MODE_MMC3A) ? (r_reload ? (r_latch == 8'd0) : (r_cnt == 8'd1))
                                           : (w_next == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= '0; r_pre <= '0; r_latch <= '0; r_cnt <= '0;
      r_a12_d <= 1'b0; r_reload <= 1'b0; r_en <= 1'b0; r_pend <= 1'b0; r_cyc <= 1'b0;
    end else begin
      if (w_run) begin
        r_a12_d <= i_a12;
        if (i_a12) r_filt <= '0;
        else if (i_m2_fall && r_filt < FW'(A12_FILT)) r_filt <= r_filt + 1'b1;
        if (i_m2_fall) r_pre <= (r_pre == PW'(CYC_DIV - 1)) ? '0 : r_pre + 1'b1;
        if (w_clk_ev) begin
          r_cnt    <= w_next;
          r_reload <= 1'b0;
          if (w_hit && r_en) r_pend <= 1'b1;
        end
        // register writes land after the counter update so they win
        if (i_commit) begin
          case (reg_sel_t'(i_sel))
            REG_IRQ_LATCH: r_latch <= i_data;
            REG_IRQ_RELOAD: begin
              r_cnt <= 8'd0; r_reload <= 1'b1;
              if (w_rambo) begin r_cyc <= i_data[0]; r_pre <= '0; end
            end
            REG_IRQ_DIS: begin r_en <= 1'b0; r_pend <= 1'b0; end
            REG_IRQ_EN:  r_en <= 1'b1;
            default: ;
          endcase
        end
      end
`ifdef MMC3_SST_EN
      if (i_sst_we) begin
        if (i_sst_addr == SST_LATCH) r_latch <= i_sst_di;
        if (i_sst_addr == SST_CNT) r_cnt <= i_sst_di;
        if (i_sst_addr == SST_FLAGS) begin
          r_en <= i_sst_di[3]; r_reload <= i_sst_di[2]; r_pend <= i_sst_di[1]; r_cyc <= i_sst_di[0];
        end
      end
`endif
    end
  end

`ifdef MMC3_SST_EN
  assign o_latch = r_latch;
  assign o_cnt   = r_cnt;
  assign o_flags = {r_en, r_reload, r_pend, r_cyc};
`endif
  assign o_irq_n = ~r_pend;

endmodule

// File: rtl/mmc3_ext_core.sv
// rtl/mmc3_ext_core.sv - MMC3B/MMC3A/RAMBO-1 mapper core: bus capture, bank file, PRG/CHR map
// Optional save-state port set guarded by MMC3_SST_EN.
module mmc3_ext_core import mmc3_pkg::*; #(
  parameter int PRG_W    = 8,
  parameter int CHR_W    = 8,
  parameter int A12_FILT = 3,
  parameter int CYC_DIV  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_map_mode,
  input  logic             i_mir_h,
  input  logic [7:0]       i_cpu_data,
  input  logic             i_cpu_a14,
  input  logic             i_cpu_a13,
  input  logic             i_cpu_a0,
  input  logic             i_cpu_ce_n,
  input  logic             i_cpu_rw,
  input  logic             i_cpu_m2,
  input  logic [2:0]       i_ppu_addr,
`ifdef MMC3_SST_EN
  input  logic             i_sst_act,
  input  logic             i_sst_we,
  input  logic [7:0]       i_sst_addr,
  input  logic [7:0]       i_sst_di,
  output logic [7:0]       o_sst_dato,
`endif
  output logic             o_irq_n,
  output logic             o_ciram_a10,
  output logic             o_ram_ce,
  output logic             o_ram_we_n,
  output logic             o_prg_ce_n,
  output logic [PRG_W-1:0] o_prg_addr,
  output logic [CHR_W-1:0] o_chr_addr
);

  logic [1:0] r_m2_sync, r_a12_sync;
  logic       r_m2_d, r_fall_d, r_cap_rw, r_cap_ce_n;
  logic [7:0] r_cap_data;
  logic [2:0] r_cap_sel;
  logic [7:0] r_bank [16];
  logic       r_chr_mode, r_prg_mode, r_k, r_mir;
  logic [3:0] r_idx;
  logic [1:0] r_a001;

  logic             w_rambo, w_k, w_commit, w_idx_ok, w_a12x;
  logic [3:0]       w_idx;
  logic [7:0]       w_chr;
  logic [PRG_W-1:0] w_fix2, w_prg;

  assign w_rambo = (map_mode_t'(i_map_mode) == MODE_RAMBO);
  assign w_k     = w_rambo & r_k;
  assign w_idx   = w_rambo ? r_idx : {1'b0, r_idx[2:0]};
  assign w_idx_ok = ~w_idx[3] | (w_idx == IDX_R8) | (w_idx == IDX_R9) | (w_idx == IDX_RF);
`ifdef MMC3_SST_EN
  assign w_commit = r_fall_d & ~r_cap_rw & ~r_cap_ce_n & ~i_sst_act;
`else
  assign w_commit = r_fall_d & ~r_cap_rw & ~r_cap_ce_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m2_sync <= '0; r_a12_sync <= '0; r_m2_d <= 1'b0; r_fall_d <= 1'b0;
      r_cap_rw <= 1'b1; r_cap_ce_n <= 1'b1; r_cap_data <= '0; r_cap_sel <= '0;
    end else begin
      r_m2_sync  <= {r_m2_sync[0], i_cpu_m2};
      r_a12_sync <= {r_a12_sync[0], i_ppu_addr[2]};
      r_m2_d     <= r_m2_sync[1];
      r_fall_d   <= r_m2_d & ~r_m2_sync[1];
      if (r_m2_sync[1]) begin
        r_cap_rw <= i_cpu_rw; r_cap_ce_n <= i_cpu_ce_n; r_cap_data <= i_cpu_data;
        r_cap_sel <= {i_cpu_a14, i_cpu_a13, i_cpu_a0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_bank[i] <= bank_reset(4'(i));
      r_chr_mode <= 1'b0; r_prg_mode <= 1'b0; r_k <= 1'b0; r_idx <= '0;
      r_mir <= i_mir_h; r_a001 <= '0;
    end
`ifdef MMC3_SST_EN
    else if (i_sst_act) begin
      if (i_sst_we) begin
        if (i_sst_addr < 8'd16) r_bank[i_sst_addr[3:0]] <= i_sst_di;
        else if (i_sst_addr == SST_R8000) begin
          {r_chr_mode, r_prg_mode, r_k} <= i_sst_di[7:5]; r_idx <= i_sst_di[3:0];
        end
        else if (i_sst_addr == SST_A000) r_mir <= i_sst_di[0];
        else if (i_sst_addr == SST_A001) r_a001 <= i_sst_di[7:6];
      end
    end
`endif
    else if (w_commit) begin
      case (reg_sel_t'(r_cap_sel))
        REG_BANK_SEL: begin
          {r_chr_mode, r_prg_mode, r_k} <= r_cap_data[7:5]; r_idx <= r_cap_data[3:0];
        end
        REG_BANK_DATA: if (w_idx_ok) r_bank[w_idx] <= r_cap_data;
        REG_MIRROR:    r_mir <= r_cap_data[0];
        REG_PRG_RAM:   r_a001 <= r_cap_data[7:6];
        default: ;
      endcase
    end
  end

  // In PRG mode 1 the fixed/RF bank and R6 swap between $8000 and $C000
  always_comb begin
    w_fix2 = w_rambo ? PRG_W'(r_bank[IDX_RF]) : {{(PRG_W-1){1'b1}}, 1'b0};
    case ({i_cpu_a14, i_cpu_a13})
      2'b00:   w_prg = r_prg_mode ? w_fix2 : PRG_W'(r_bank[6]);
      2'b01:   w_prg = PRG_W'(r_bank[7]);
      2'b10:   w_prg = r_prg_mode ? PRG_W'(r_bank[6]) : w_fix2;
      default: w_prg = '1;
    endcase
  end

  assign w_a12x = i_ppu_addr[2] ^ r_chr_mode;
  always_comb begin
    w_chr = 8'd0;
    if (w_a12x) w_chr = r_bank[4'd2 + {2'b00, i_ppu_addr[1:0]}];
    else if (w_k) begin
      case (i_ppu_addr[1:0])
        2'b00:   w_chr = r_bank[0];
        2'b01:   w_chr = r_bank[IDX_R8];
        2'b10:   w_chr = r_bank[1];
        default: w_chr = r_bank[IDX_R9];
      endcase
    end else w_chr = {r_bank[{3'b000, i_ppu_addr[1]}][7:1], i_ppu_addr[0]};
  end

  assign o_prg_addr  = w_prg;
  assign o_chr_addr  = CHR_W'(w_chr);
  assign o_ciram_a10 = r_mir ? i_ppu_addr[1] : i_ppu_addr[0];
  assign o_ram_ce    = i_cpu_ce_n & i_cpu_a14 & i_cpu_a13 & r_a001[1];
  assign o_ram_we_n  = i_cpu_rw | r_a001[0];
  assign o_prg_ce_n  = i_cpu_ce_n | ~i_cpu_rw;

`ifdef MMC3_SST_EN
  logic [7:0] w_latch, w_cnt;
  logic [3:0] w_flags;
  always_comb begin
    o_sst_dato = 8'hFF;
    if (i_sst_addr < 8'd16) o_sst_dato = r_bank[i_sst_addr[3:0]];
    else if (i_sst_addr == SST_R8000) o_sst_dato = {r_chr_mode, r_prg_mode, r_k, 1'b0, r_idx};
    else if (i_sst_addr == SST_A000) o_sst_dato = {7'd0, r_mir};
    else if (i_sst_addr == SST_A001) o_sst_dato = {r_a001, 6'd0};
    else if (i_sst_addr == SST_LATCH) o_sst_dato = w_latch;
    else if (i_sst_addr == SST_CNT) o_sst_dato = w_cnt;
    else if (i_sst_addr == SST_FLAGS) o_sst_dato = {4'd0, w_flags};
  end
`endif

  mmc3_irq_ctr #(.A12_FILT(A12_FILT), .CYC_DIV(CYC_DIV)) u_irq (
    .clk       (clk),
    .rst       (rst),
    .i_commit  (w_commit),
    .i_sel     (r_cap_sel),
    .i_data    (r_cap_data),
    .i_a12     (r_a12_sync[1]),
    .i_m2_fall (r_fall_d),
    .i_mode    (i_map_mode),
`ifdef MMC3_SST_EN
    .i_freeze  (i_sst_act),
    .i_sst_we  (i_sst_act & i_sst_we),
    .i_sst_addr(i_sst_addr),
    .i_sst_di  (i_sst_di),
    .o_latch   (w_latch),
    .o_cnt     (w_cnt),
    .o_flags   (w_flags),
`endif
    .o_irq_n   (o_irq_n)
  );

endmodule
